// File: rtl/hw_accel_frame_sequencer.sv
// Frame sequencer for the accelerator DMA write path: splits frames into bursts, flushes after each frame.
// Optional stall watchdog enabled by defining HW_ACCEL_SEQ_TIMEOUT_EN.
module hw_accel_frame_sequencer #(
    parameter int FRAME_WIDTH         = 640,
    parameter int FRAME_HEIGHT        = 480,
    parameter int DMA_TRANSFER_LENGTH = 1920,
    parameter int RST_CYCLES          = 4,
    parameter int FRAME_CNT_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES      = 65535
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_req,
    input  logic                       auto_rearm,
    input  logic                       abort,
    input  logic                       dma_wready,
    input  logic                       out_fifo_empty,
    input  logic                       out_fifo_rvalid,
    output logic                       out_fifo_re,
    output logic                       dma_wvalid,
    output logic                       dma_wlast,
    output logic                       accel_rst,
    output logic                       busy,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       timeout_err
);

    localparam int FW = FRAME_WIDTH * FRAME_HEIGHT;
    localparam int BW = (DMA_TRANSFER_LENGTH > 1) ? $clog2(DMA_TRANSFER_LENGTH) : 1;
    localparam int PW = (FW > 1) ? $clog2(FW) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(DMA_TRANSFER_LENGTH - 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(FW - 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_WAIT  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              start_q;
    logic              start_pulse;
    logic [BW-1:0]     beat_cnt;
    logic [PW-1:0]     pix_cnt;
    logic [RW-1:0]     flush_cnt;
    logic              flush_last;
    logic              flush_entry;
    logic              done_arm;
    logic              frame_done_r;
    logic              timeout_hit;
    logic              abort_evt;
    logic [FRAME_CNT_WIDTH-1:0] frame_count_r;

    assign start_pulse = start_req & ~start_q;
    assign flush_last  = (flush_cnt == RST_LAST);
    assign flush_entry = (state != S_FLUSH) && (next_state == S_FLUSH);
    assign abort_evt   = abort | timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start_pulse) next_state = S_XFER;
            end
            S_XFER: begin
                if (abort_evt) begin
                    next_state = S_FLUSH;
                end else if (dma_wlast) begin
                    if (pix_cnt == PIX_LAST) next_state = S_FLUSH;
                    else if (!auto_rearm)    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort)            next_state = S_FLUSH;
                else if (start_pulse) next_state = S_XFER;
            end
            S_FLUSH: begin
                if (flush_last) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake is purely combinational so a beat is never lost when the state changes.
    always_comb begin
        out_fifo_re = (state == S_XFER) & dma_wready & ~out_fifo_empty;
        dma_wvalid  = out_fifo_rvalid & out_fifo_re;
        dma_wlast   = dma_wvalid & (beat_cnt == BEAT_LAST);
        accel_rst   = (state == S_FLUSH);
        busy        = (state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= 1'b0;
            beat_cnt  <= '0;
            pix_cnt   <= '0;
            flush_cnt <= '0;
        end else begin
            start_q <= start_req;
            if (state == S_IDLE || flush_entry) begin
                beat_cnt <= '0;
                pix_cnt  <= '0;
            end else if (dma_wvalid) begin
                beat_cnt <= dma_wlast ? '0 : beat_cnt + 1'b1;
                pix_cnt  <= pix_cnt + 1'b1;
            end
            flush_cnt <= (state == S_FLUSH) ? flush_cnt + 1'b1 : '0;
        end
    end

    // Only the final-burst path enters FLUSH from XFER without an abort; that frame earns frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_arm      <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_count_r <= '0;
        end else begin
            if (flush_entry) begin
                done_arm <= (state == S_XFER) & ~abort_evt;
            end
            frame_done_r <= (state == S_FLUSH) & flush_last & done_arm;
            if ((state == S_FLUSH) && flush_last && done_arm) begin
                frame_count_r <= frame_count_r + 1'b1;
            end
        end
    end

    assign frame_done  = frame_done_r;
    assign frame_count = frame_count_r;

`ifdef HW_ACCEL_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] STALL_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] stall_cnt;
    logic          timeout_err_r;

    assign timeout_hit = (state == S_XFER) && (stall_cnt == STALL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt     <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if (state != S_XFER || dma_wvalid) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_LAST) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_r;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
